// File: rtl/acq_pkg.sv
// Shared widths, state encoding and peak record for the acquisition peak sorter.
package acq_pkg;
  localparam int AMP_W = 9;
  localparam int GRP_W = 11;
  localparam int CNT_W = 13;
  localparam int PH_W  = GRP_W + 2;
  localparam int NS_W  = AMP_W + CNT_W;

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, HOLD = 2'd2} state_t;

  typedef struct packed {
    logic [AMP_W-1:0] amp;
    logic [PH_W-1:0]  ph;
  } peak_t;
endpackage

// File: rtl/acq_peak_sort_if.sv
// Sample stream in, sorted result set out; slave is the sorter, master the controller side.
interface acq_peak_sort_if
  import acq_pkg::*;
();
  logic             in_valid;
  logic             in_ready;
  logic [AMP_W-1:0] in_amp;
  logic [1:0]       in_lane;
  logic [GRP_W-1:0] in_grp;
  logic             in_last;
  logic             res_valid;
  logic             res_ack;
  logic [AMP_W-1:0] peak_amp0, peak_amp1, peak_amp2;
  logic [PH_W-1:0]  peak_ph0, peak_ph1, peak_ph2;
  logic [NS_W-1:0]  noise_sum;
  logic [CNT_W-1:0] sample_cnt;

  modport slave (
    input  in_valid, in_amp, in_lane, in_grp, in_last, res_ack,
    output in_ready, res_valid, peak_amp0, peak_amp1, peak_amp2,
           peak_ph0, peak_ph1, peak_ph2, noise_sum, sample_cnt
  );

  modport master (
    output in_valid, in_amp, in_lane, in_grp, in_last, res_ack,
    input  in_ready, res_valid, peak_amp0, peak_amp1, peak_amp2,
           peak_ph0, peak_ph1, peak_ph2, noise_sum, sample_cnt
  );
endinterface

// File: rtl/peak_insert.sv
// Combinational insert of one candidate into a 3-entry descending list; ties keep the older entry.
module peak_insert
  import acq_pkg::*;
(
  input  peak_t [2:0] cur,
  input  peak_t       cand,
  output peak_t [2:0] nxt
);
  always_comb begin
    nxt = cur;
    // strict compares: an equal or zero candidate never displaces
    if (cand.amp > cur[0].amp) begin
      nxt[0] = cand;
      nxt[1] = cur[0];
      nxt[2] = cur[1];
    end else if (cand.amp > cur[1].amp) begin
      nxt[1] = cand;
      nxt[2] = cur[1];
    end else if (cand.amp > cur[2].amp) begin
      nxt[2] = cand;
    end
  end
endmodule

// File: rtl/acq_peak_sort.sv
// Per-round top-3 peak tracker with saturating noise sum / sample count and valid/ack result hold.
module acq_peak_sort
  import acq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  acq_peak_sort_if.slave  bus
);
  state_t           state, state_nxt;
  peak_t [2:0]      pk, pk_ins;
  peak_t            cand;
  logic [NS_W-1:0]  ns;
  logic [NS_W:0]    ns_add;
  logic [CNT_W-1:0] cnt;
  logic             rv;
  logic             acc;

  assign bus.in_ready = (state == COLLECT) && !start;
  assign acc          = bus.in_valid && bus.in_ready;
  assign cand         = {bus.in_amp, bus.in_grp, bus.in_lane};
  assign ns_add       = {1'b0, ns} + {{(NS_W+1-AMP_W){1'b0}}, bus.in_amp};

  peak_insert u_ins (.cur(pk), .cand(cand), .nxt(pk_ins));

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (acc && bus.in_last) state_nxt = HOLD;
      HOLD:    if (bus.res_ack)        state_nxt = IDLE;
      default: state_nxt = state;
    endcase
    // start overrides both the last-sample and the ack transitions
    if (start) state_nxt = COLLECT;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      pk  <= '0;
      ns  <= '0;
      cnt <= '0;
      rv  <= 1'b0;
    end else begin
      rv <= (state_nxt == HOLD);
      if (acc) begin
        pk  <= pk_ins;
        ns  <= ns_add[NS_W] ? '1 : ns_add[NS_W-1:0];
        cnt <= (&cnt) ? cnt : cnt + 1'b1;
      end
    end
  end

  assign bus.res_valid  = rv;
  assign bus.peak_amp0  = pk[0].amp;
  assign bus.peak_amp1  = pk[1].amp;
  assign bus.peak_amp2  = pk[2].amp;
  assign bus.peak_ph0   = pk[0].ph;
  assign bus.peak_ph1   = pk[1].ph;
  assign bus.peak_ph2   = pk[2].ph;
  assign bus.noise_sum  = ns;
  assign bus.sample_cnt = cnt;
endmodule
